// File: rtl/minibyte_arb_pkg.sv
// Minibyte bus arbiter shared types: bus widths, default window base, FSM states.
// No ports; imported by minibyte_bus_arbiter.
package minibyte_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] INT_BASE_DEF = 7'h78;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RECOVER
  } state_e;

endpackage

// File: rtl/minibyte_arb_pick.sv
// Combinational winner select for the two Minibyte bus requesters.
// Ports: req0_i/req1_i requests, ptr_i tie-break port (MINIBYTE_ARB_RR_EN only),
// gnt_o winning port id, any_o at least one request.
module minibyte_arb_pick (
  input  logic req0_i,
  input  logic req1_i,
`ifdef MINIBYTE_ARB_RR_EN
  input  logic ptr_i,
`endif
  output logic gnt_o,
  output logic any_o
);

  assign any_o = req0_i | req1_i;

  always_comb begin
    gnt_o = 1'b0;
    unique case (1'b1)
      (req0_i && req1_i): begin
`ifdef MINIBYTE_ARB_RR_EN
        gnt_o = ptr_i;
`else
        gnt_o = 1'b0;
`endif
      end
      (!req0_i && req1_i): gnt_o = 1'b1;
      default:             gnt_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/minibyte_bus_arbiter.sv
// Two-port Minibyte memory bus sequencer: IDLE -> ACCESS (wait states) -> RECOVER.
// Ports: clk_in/rst_in (async low), halt_in, req{0,1}_{in,addr_in,we_in,data_in},
// bus_data_in; registered bus pins addr/data/we/drive_out, req{0,1}_done_out,
// rdata_out, busy_out, grant_id_out. Macro MINIBYTE_ARB_RR_EN selects round-robin.
module minibyte_bus_arbiter
  import minibyte_arb_pkg::*;
#(
  parameter int unsigned       WAIT_STATES = 2,
  parameter logic [ADDR_W-1:0] INT_BASE    = INT_BASE_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              halt_in,
  input  logic              req0_in,
  input  logic [ADDR_W-1:0] req0_addr_in,
  input  logic              req0_we_in,
  input  logic [DATA_W-1:0] req0_data_in,
  input  logic              req1_in,
  input  logic [ADDR_W-1:0] req1_addr_in,
  input  logic              req1_we_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [DATA_W-1:0] bus_data_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              we_out,
  output logic              drive_out,
  output logic              req0_done_out,
  output logic              req1_done_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic              busy_out,
  output logic              grant_id_out
);

  if (WAIT_STATES > 7) begin : g_ws_chk
    $error("WAIT_STATES must be in 0..7");
  end

  localparam logic [2:0] WS3 = 3'(WAIT_STATES);

  state_e            st_q, st_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic              wr_q, wr_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              gid_q, gid_d;
  logic              busy_q;

  logic              gnt;
  logic              any_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_we;

`ifdef MINIBYTE_ARB_RR_EN
  // Port that wins the next tie; flips to the other port after each service.
  logic ptr_q, ptr_d;

  minibyte_arb_pick u_pick (
    .req0_i (req0_in),
    .req1_i (req1_in),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .any_o  (any_req)
  );
`else
  minibyte_arb_pick u_pick (
    .req0_i (req0_in),
    .req1_i (req1_in),
    .gnt_o  (gnt),
    .any_o  (any_req)
  );
`endif

  assign sel_addr = gnt ? req1_addr_in : req0_addr_in;
  assign sel_data = gnt ? req1_data_in : req0_data_in;
  assign sel_we   = gnt ? req1_we_in   : req0_we_in;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    gid_d   = gid_q;
    wr_d    = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
`ifdef MINIBYTE_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    unique case (st_q)
      IDLE: begin
        if (any_req && !halt_in) begin
          st_d   = ACCESS;
          addr_d = sel_addr;
          wdat_d = sel_data;
          wr_d   = sel_we;
          gid_d  = gnt;
          // Onboard register-RAM window needs no wait states.
          cnt_d  = (sel_addr >= INT_BASE) ? 3'd0 : WS3;
        end
      end
      ACCESS: begin
        wr_d = wr_q;
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          if (!wr_q) rdat_d = bus_data_in;
          wr_d    = 1'b0;
          done0_d = !gid_q;
          done1_d = gid_q;
          st_d    = RECOVER;
        end
      end
      RECOVER: begin
        st_d = IDLE;
`ifdef MINIBYTE_ARB_RR_EN
        ptr_d = !gid_q;
`endif
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      st_q    <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      wr_q    <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      gid_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      wr_q    <= wr_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      gid_q   <= gid_d;
      busy_q  <= (st_d != IDLE);
    end
  end

`ifdef MINIBYTE_ARB_RR_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end
`endif

  assign addr_out      = addr_q;
  assign data_out      = wdat_q;
  assign we_out        = wr_q;
  assign drive_out     = wr_q;
  assign req0_done_out = done0_q;
  assign req1_done_out = done1_q;
  assign rdata_out     = rdat_q;
  assign busy_out      = busy_q;
  assign grant_id_out  = gid_q;

endmodule

// File: tb/tb_minibyte_bus_arbiter.sv
// Self-checking bench for minibyte_bus_arbiter: directed scenarios plus
// randomized traffic against a transaction-level timing model.
module tb_minibyte_bus_arbiter;

  localparam int WS = 2;
  localparam int IB = 'h78;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       halt = 1'b0;
  logic       r0 = 1'b0, r1 = 1'b0;
  logic [6:0] a0 = '0, a1 = '0;
  logic       w0 = 1'b0, w1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, bus = '0;

  logic [6:0] addr_out;
  logic [7:0] data_out, rdata_out;
  logic       we_out, drive_out, req0_done_out, req1_done_out;
  logic       busy_out, grant_id_out;

  minibyte_bus_arbiter dut (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .halt_in       (halt),
    .req0_in       (r0),
    .req0_addr_in  (a0),
    .req0_we_in    (w0),
    .req0_data_in  (d0),
    .req1_in       (r1),
    .req1_addr_in  (a1),
    .req1_we_in    (w1),
    .req1_data_in  (d1),
    .bus_data_in   (bus),
    .addr_out      (addr_out),
    .data_out      (data_out),
    .we_out        (we_out),
    .drive_out     (drive_out),
    .req0_done_out (req0_done_out),
    .req1_done_out (req1_done_out),
    .rdata_out     (rdata_out),
    .busy_out      (busy_out),
    .grant_id_out  (grant_id_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Model: the last granted transaction as absolute cycle windows.
  int         t_start, t_end, t_done, free_at;
  bit         t_port, t_we, m_gid, last_srv;
  logic [6:0] m_addr;
  logic [7:0] m_data, m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({addr_out, data_out, we_out, drive_out, req0_done_out,
                req1_done_out, rdata_out, busy_out, grant_id_out});
  endfunction

  task automatic model_reset();
    t_start = -10; t_end = -20; t_done = -20; free_at = cyc;
    t_port = 0; t_we = 0; m_gid = 0; last_srv = 1;
    m_addr = '0; m_data = '0; m_rdata = '0;
  endtask

  task automatic model_check();
    bit acc;
    acc = (cyc >= t_start) && (cyc <= t_end);
    chk("addr",  32'(addr_out), 32'(m_addr));
    chk("wdata", 32'(data_out), 32'(m_data));
    chk("we",    32'(we_out), 32'(t_we && acc));
    chk("drive", 32'(drive_out), 32'(t_we && acc));
    chk("done0", 32'(req0_done_out), 32'(cyc == t_done && !t_port));
    chk("done1", 32'(req1_done_out), 32'(cyc == t_done && t_port));
    chk("rdata", 32'(rdata_out), 32'(m_rdata));
    chk("busy",  32'(busy_out), 32'(cyc >= t_start && cyc <= t_done));
    chk("gid",   32'(grant_id_out), 32'(m_gid));
  endtask

  task automatic model_decide();
    bit w;
    int ws;
    if (cyc == t_end && !t_we) m_rdata = bus;
    if (cyc == t_done) last_srv = t_port;
    if (cyc >= free_at && !halt && (r0 || r1)) begin
`ifdef MINIBYTE_ARB_RR_EN
      w = (r0 && r1) ? !last_srv : r1;
`else
      w = !r0;
`endif
      t_port = w;
      m_gid  = w;
      m_addr = w ? a1 : a0;
      m_data = w ? d1 : d0;
      t_we   = w ? w1 : w0;
      ws = (int'(m_addr) >= IB) ? 0 : WS;
      t_start = cyc + 1;
      t_end   = cyc + 1 + ws;
      t_done  = cyc + 2 + ws;
      free_at = cyc + 3 + ws;
    end
  endtask

  // Check this cycle, predict the edge, then move to the next cycle (+1).
  task automatic tick();
    @(negedge clk);
    model_check();
    model_decide();
    @(posedge clk);
    cyc++;
    #1;
    if (cyc == t_done) begin
      if (t_port) r1 = 1'b0;
      else        r0 = 1'b0;
    end
  endtask

  function automatic logic [6:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 7'(IB + int'($urandom_range(0, 7)));
    return 7'($urandom_range(0, 127));
  endfunction

  task automatic rand_drive();
    bit own0, own1;
    own0 = (t_port == 0) && (cyc >= t_start) && (cyc <= t_done);
    own1 = (t_port == 1) && (cyc >= t_start) && (cyc <= t_done);
    if (own0) begin
      if ($urandom_range(0, 3) == 0) begin a0 = rnd_addr(); d0 = 8'($urandom); end
      if ($urandom_range(0, 7) == 0) r0 = 1'b0;
    end else if (!r0 && $urandom_range(0, 2) == 0) begin
      r0 = 1'b1; a0 = rnd_addr(); w0 = 1'($urandom); d0 = 8'($urandom);
    end
    if (own1) begin
      if ($urandom_range(0, 3) == 0) begin a1 = rnd_addr(); d1 = 8'($urandom); end
      if ($urandom_range(0, 7) == 0) r1 = 1'b0;
    end else if (!r1 && $urandom_range(0, 2) == 0) begin
      r1 = 1'b1; a1 = rnd_addr(); w1 = 1'($urandom); d1 = 8'($urandom);
    end
    if ($urandom_range(0, 9) == 0) halt = !halt;
    bus = 8'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #2;
    chk("reset_outs", all_outs(), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick(); tick();

    // External write, port 0.
    r0 = 1; a0 = 7'h10; w0 = 1; d0 = 8'hA5;
    tick();
    chk("t1_acc", 32'({addr_out, data_out, we_out, drive_out}),
        32'({7'h10, 8'hA5, 2'b11}));
    tick(); tick(); tick();
    chk("t1_done", 32'({we_out, drive_out, req0_done_out}), 32'(3'b001));
    tick();
    chk("t1_idle", 32'(busy_out), 32'd0);

    // Internal-window read, port 1.
    r1 = 1; a1 = 7'h7A; w1 = 0; d1 = 8'h99; bus = 8'h3C;
    tick();
    chk("t2_acc", 32'({we_out, drive_out, busy_out}), 32'(3'b001));
    tick();
    chk("t2_done", 32'({req1_done_out, rdata_out, grant_id_out}),
        32'({1'b1, 8'h3C, 1'b1}));
    tick();

    // Simultaneous external requests.
    r0 = 1; a0 = 7'h20; w0 = 1; d0 = 8'h11;
    r1 = 1; a1 = 7'h30; w1 = 0; d1 = 8'h22;
    repeat (4) tick();
    chk("t3_done0", 32'({req0_done_out, req1_done_out}), 32'(2'b10));
    repeat (5) tick();
    chk("t3_done1", 32'({req0_done_out, req1_done_out}), 32'(2'b01));
    tick();

    // Halt holds off a pending request.
    halt = 1; r0 = 1; a0 = 7'h05; w0 = 0;
    repeat (10) begin
      tick();
      chk("t4_halt_busy", 32'(busy_out), 32'd0);
    end
    halt = 0;
    tick();
    chk("t4_grant", 32'(busy_out), 32'd1);
    repeat (3) tick();
    chk("t4_done", 32'(req0_done_out), 32'd1);
    tick();

    // Reset during the second ACCESS cycle.
    r0 = 1; a0 = 7'h40; w0 = 1; d0 = 8'h5A;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", all_outs(), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    tick();
    chk("t5_restart", 32'({busy_out, we_out, addr_out}), 32'({2'b11, 7'h40}));
    repeat (3) tick();
    chk("t5_done", 32'(req0_done_out), 32'd1);
    tick();

    // Requester inputs change after the grant.
    r0 = 1; a0 = 7'h10; w0 = 1; d0 = 8'hC3;
    tick();
    r0 = 0; a0 = 7'h55; d0 = 8'h00;
    repeat (3) tick();
    chk("t6_latched", 32'({addr_out, data_out, req0_done_out}),
        32'({7'h10, 8'hC3, 1'b1}));
    tick();

    repeat (3000) begin
      rand_drive();
      tick();
    end
    halt = 0; r0 = 0; r1 = 0;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
